// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 16;
  localparam int FETCH_INSTR_W = 16;

  // Opcode value that marks a halt instruction.
  localparam logic [3:0] HLT_OPC = 4'hF;

  // Instruction presented to decode while the prefetch queue is empty.
  localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR = 16'hB0FF;

  // One prefetch queue entry: the instruction and the address it came from.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Opcode lives in the top nibble of the instruction word.
  function automatic logic [3:0] opcode(input logic [FETCH_INSTR_W-1:0] instr);
    return instr[FETCH_INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Generic synchronous FIFO used as the prefetch queue.
// Flush has priority over push and pop; push while full is accepted only
// together with a pop, so occupancy stays unchanged in that case.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  // Entry storage; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: keeps one IM read in flight per cycle while the
// prefetch queue has room, hands {instr, pc} to decode, and handles branch
// redirect (flush) and halt detection at the queue head.
module fetch_queue_unit #(
  parameter int                 ADDR_W         = 16,
  parameter int                 INSTR_W        = 16,
  parameter int                 DEPTH          = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC       = '0,
  parameter logic [3:0]         HLT_OPC        = fetch_pkg::HLT_OPC,
  parameter logic [INSTR_W-1:0] NOP_INSTR      = fetch_pkg::NOP_INSTR,
  parameter int                 REDIRECT_GUARD = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  im_addr,
  output logic               im_rd_en,
  input  logic [INSTR_W-1:0] im_instr,
  input  logic               stall,
  input  logic               branch,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               instr_valid,
  output logic               hlt,
  output logic               branch_init
);

  import fetch_pkg::*;

  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int GUARD_W = (REDIRECT_GUARD > 0) ? $clog2(REDIRECT_GUARD + 1) : 1;
  localparam logic [GUARD_W-1:0] GUARD_MAX = GUARD_W'(REDIRECT_GUARD);
  localparam logic [CNT_W:0]     DEPTH_C   = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]  fetch_pc_reg;
  logic               inflight_reg;
  logic [ADDR_W-1:0]  inflight_pc_reg;
  logic [GUARD_W-1:0] issue_cnt_reg;
  logic [ADDR_W-1:0]  pc_hold_reg;

  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic               redirect;
  logic               room;
  logic               issue;
  logic               dequeue;

  assign head_pc    = fifo_head[ENTRY_W-1 -: ADDR_W];
  assign head_instr = fifo_head[INSTR_W-1:0];

  assign branch_init = (issue_cnt_reg >= GUARD_MAX);
  assign redirect    = branch && branch_init;

  // A redirect in the same cycle flushes the halting head, so it also cancels the halt.
  assign hlt = !fifo_empty && (opcode(head_instr) == HLT_OPC) && !redirect;

  // Queued entries plus the outstanding read must leave space for the new response.
  assign room     = !fifo_full && (({1'b0, fifo_count} + (CNT_W + 1)'(inflight_reg)) < DEPTH_C);
  assign issue    = rst_n && !hlt && room;
  assign dequeue  = !fifo_empty && !stall && !hlt;
  assign im_rd_en = issue;
  assign im_addr  = fetch_pc_reg;

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? NOP_INSTR : head_instr;
  assign instr_pc    = fifo_empty ? pc_hold_reg : head_pc;
  assign pc_next     = instr_pc + 1'b1;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data ({inflight_pc_reg, im_instr}),
    .pop       (dequeue),
    .flush     (redirect),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Fetch PC, in-flight tracking, guard counter and the held head PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      issue_cnt_reg   <= '0;
      pc_hold_reg     <= RESET_PC;
    end else begin
      if (!fifo_empty) pc_hold_reg <= head_pc;
      if (issue && (issue_cnt_reg != GUARD_MAX)) issue_cnt_reg <= issue_cnt_reg + 1'b1;
      if (redirect) begin
        // Any read issued this cycle belongs to the old path: drop it.
        fetch_pc_reg <= branch_addr;
        inflight_reg <= 1'b0;
      end else begin
        inflight_reg <= issue;
        if (issue) begin
          fetch_pc_reg    <= fetch_pc_reg + 1'b1;
          inflight_pc_reg <= fetch_pc_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: stimulus queues the expected
// {pc, instr} stream, a monitor checks every accepted head against it.
module tb_fetch_queue_unit;

  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] im_instr = '0;
  logic        stall = 1'b1;
  logic        branch = 1'b0;
  logic [15:0] branch_addr = '0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] pc_next;
  logic        instr_valid;
  logic        hlt;
  logic        branch_init;

  int           errors = 0;
  int           checks = 0;
  bit           halt_mode = 1'b0;
  fetch_entry_t exp_q[$];

  fetch_queue_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_addr     (im_addr),
    .im_rd_en    (im_rd_en),
    .im_instr    (im_instr),
    .stall       (stall),
    .branch      (branch),
    .branch_addr (branch_addr),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_next     (pc_next),
    .instr_valid (instr_valid),
    .hlt         (hlt),
    .branch_init (branch_init)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] im_data(input logic [15:0] a);
    if (halt_mode && a == 16'd5) return 16'hF000;
    return 16'h1000 + a;
  endfunction

  // Synchronous instruction memory model.
  always @(posedge clk) begin
    if (im_rd_en) im_instr <= im_data(im_addr);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic push_seq(input logic [15:0] base, input int n);
    fetch_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = base + 16'(i);
      e.instr = im_data(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  // Assert reset, check reset outputs immediately, release so cycle 0 begins.
  task automatic do_reset();
    rst_n  = 1'b0;
    branch = 1'b0;
    #1;
    chk("rst_rd_en", 32'(im_rd_en), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'h0000B0FF);
    chk("rst_hlt", 32'(hlt), 32'd0);
    chk("rst_branch_init", 32'(branch_init), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  // Monitor: every head accepted by decode is compared to the scoreboard.
  initial begin
    fetch_entry_t got;
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && !stall && !hlt && !(branch && branch_init)) begin
        got.pc    = instr_pc;
        got.instr = instr;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL deq_unexpected: got pc=%h instr=%h required no dequeue", got.pc, got.instr);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL deq: got pc=%h instr=%h required pc=%h instr=%h",
                     got.pc, got.instr, e.pc, e.instr);
          end else begin
            $display("deq pc=%h instr=%h pc_next=%h", got.pc, got.instr, pc_next);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential fetch; an early branch is ignored while the guard is active.
    stall = 1'b0;
    push_seq(16'h0000, 10);
    do_reset();
    chk("A_c0_rd_en", 32'(im_rd_en), 32'd1);
    chk("A_c0_addr", 32'(im_addr), 32'h0);
    chk("A_c0_valid", 32'(instr_valid), 32'd0);
    cyc();
    branch = 1'b1;
    branch_addr = 16'h0080;
    #1;
    chk("A_c1_branch_init", 32'(branch_init), 32'd0);
    chk("A_c1_addr", 32'(im_addr), 32'h1);
    cyc();
    branch = 1'b0;
    #1;
    chk("A_c2_valid", 32'(instr_valid), 32'd1);
    chk("A_c2_instr", 32'(instr), 32'h1000);
    chk("A_c2_pc", 32'(instr_pc), 32'h0);
    chk("A_c2_pc_next", 32'(pc_next), 32'h1);
    chk("A_c2_branch_init", 32'(branch_init), 32'd0);
    cyc();
    chk("A_c3_branch_init", 32'(branch_init), 32'd1);
    cycles(9);
    stall = 1'b1;
    cyc();
    chk("A_drain", 32'(exp_q.size()), 32'd0);

    // Stall back-pressure: issue stops once four entries are accounted for.
    stall = 1'b1;
    do_reset();
    cycles(3);
    chk("B_c3_rd_en", 32'(im_rd_en), 32'd1);
    cyc();
    for (int i = 4; i < 10; i++) begin
      chk("B_stall_rd_en", 32'(im_rd_en), 32'd0);
      chk("B_stall_pc", 32'(instr_pc), 32'h0);
      cyc();
    end
    push_seq(16'h0000, 5);
    stall = 1'b0;
    cycles(5);
    stall = 1'b1;
    cyc();
    chk("B_drain", 32'(exp_q.size()), 32'd0);

    // Redirect with 3 queued + 1 in flight, against a pending enqueue.
    stall = 1'b1;
    do_reset();
    cycles(4);
    chk("C_c4_rd_en", 32'(im_rd_en), 32'd0);
    push_seq(16'h0040, 2);
    stall = 1'b0;
    branch = 1'b1;
    branch_addr = 16'h0040;
    cyc();
    branch = 1'b0;
    #1;
    chk("C_c5_valid", 32'(instr_valid), 32'd0);
    chk("C_c5_instr", 32'(instr), 32'h0000B0FF);
    chk("C_c5_addr", 32'(im_addr), 32'h40);
    chk("C_c5_rd_en", 32'(im_rd_en), 32'd1);
    chk("C_c5_pc_hold", 32'(instr_pc), 32'h0);
    cyc();
    chk("C_c6_valid", 32'(instr_valid), 32'd0);
    chk("C_c6_addr", 32'(im_addr), 32'h41);
    cyc();
    chk("C_c7_valid", 32'(instr_valid), 32'd1);
    chk("C_c7_pc", 32'(instr_pc), 32'h40);
    cycles(2);
    chk("C_pre_reset_drain", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream, then restart at RESET_PC.
    push_seq(16'h0000, 3);
    do_reset();
    chk("R_c0_addr", 32'(im_addr), 32'h0);
    chk("R_c0_rd_en", 32'(im_rd_en), 32'd1);
    cycles(5);
    stall = 1'b1;
    cyc();
    chk("R_drain", 32'(exp_q.size()), 32'd0);

    // Halt at pc 5, frozen state, then released by a redirect.
    halt_mode = 1'b1;
    stall = 1'b0;
    push_seq(16'h0000, 5);
    do_reset();
    cycles(7);
    for (int i = 0; i < 20; i++) begin
      chk("D_hlt", 32'(hlt), 32'd1);
      chk("D_rd_en", 32'(im_rd_en), 32'd0);
      chk("D_pc", 32'(instr_pc), 32'h5);
      chk("D_instr", 32'(instr), 32'hF000);
      cyc();
    end
    push_seq(16'h0010, 4);
    branch = 1'b1;
    branch_addr = 16'h0010;
    #1;
    chk("D_redirect_hlt", 32'(hlt), 32'd0);
    chk("D_redirect_branch_init", 32'(branch_init), 32'd1);
    cyc();
    branch = 1'b0;
    #1;
    chk("D_resume_addr", 32'(im_addr), 32'h10);
    chk("D_resume_valid", 32'(instr_valid), 32'd0);
    cycles(6);
    stall = 1'b1;
    cyc();
    chk("D_drain", 32'(exp_q.size()), 32'd0);
    chk("D_after_hlt", 32'(hlt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
